gate_resp_checker: RTL and testbench
====================================

GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
REQ-001 SHALL have parameter TRUTH_TABLE, default 4'b1001, meaning expected y indexed by {a,b} (4'b1001 = XNOR).
REQ-002 SHALL have parameter ERR_W, default 8, meaning width of the mismatch counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: begins or restarts a check run.
REQ-006 SHALL have port in_valid, input, 1 bit: a/b/y sample presented.
REQ-007 SHALL have port in_ready, output, 1 bit: checker accepts a sample this cycle.
REQ-008 SHALL have ports a, b and y, each input, 1 bit: stimulus pair and gate-under-test response.
REQ-009 SHALL have port err_count, output, ERR_W bits: mismatches in the current run.
REQ-010 SHALL have port cov_map, output, 4 bits: bit {a,b} set once that combination has been accepted.
REQ-011 SHALL have port mismatch, output, 1 bit: one-cycle pulse, cycle after a failing accept.
REQ-012 SHALL have ports done and pass, each output, 1 bit: run complete, and run complete with zero errors.
REQ-013 SHALL have ports first_err_valid (output, 1 bit) and first_err_vec (output, 3 bits = {a,b,y}).

Function
REQ-014 SHALL implement FSM states IDLE, CHECK and DONE.
REQ-015 SHALL make these transitions: start in IDLE or DONE -> CHECK; start in CHECK -> CHECK (restart); cov_map reaching 4'b1111 -> DONE.
REQ-016 SHALL clear err_count, cov_map and the first-error record on every start accepted into CHECK.
REQ-017 SHALL drive in_ready = (state==CHECK) && !start, combinationally.
REQ-018 SHALL define accept as in_valid && in_ready, with expected = TRUTH_TABLE[{a,b}].
REQ-019 SHALL on accept set cov_map[{a,b}] at the next edge.
REQ-020 SHALL on accept with y != expected increment err_count at the next edge, saturating at 2^ERR_W-1, and pulse mismatch high for exactly that next cycle.
REQ-021 SHALL count repeated combinations on every accept; repeats do not affect completion.
REQ-022 SHALL enter DONE on the edge following the accept that completes cov_map, including that accept's error update.
REQ-023 SHALL hold done=1 only in DONE, and drive pass = done && (err_count==0).
REQ-024 SHALL give start simultaneous with a sample in CHECK priority: the sample is not accepted (in_ready low).
REQ-025 SHALL ignore in_valid in IDLE and DONE and leave all outputs unchanged.

Reset
REQ-026 SHALL when rst_n=0 at a clock edge force: state IDLE, in_ready 0, err_count 0, cov_map 0, mismatch 0, done 0, pass 0, first_err_valid 0, first_err_vec 0.
REQ-027 SHALL let reset mid-run abort the run with no partial results retained.

Configuration
REQ-028 SHALL with macro GATE_RESP_CHECKER_FIRST_ERR_EN defined latch {a,b,y} of the first failing accept in a run into first_err_vec, set first_err_valid, and hold both until start or reset.
REQ-029 SHALL without GATE_RESP_CHECKER_FIRST_ERR_EN keep the ports present, tie both to 0, and omit the capture logic.

Structure
REQ-030 SHALL place the state typedef (IDLE/CHECK/DONE) and truth-table constants (AND_TT 4'b1000, OR_TT 4'b1110, XOR_TT 4'b0110, XNOR_TT 4'b1001, NAND_TT 4'b0111, NOR_TT 4'b0001) in package gate_chk_pkg.
REQ-031 SHALL isolate the expected-value lookup in one sub-module, gate_chk_expect (TRUTH_TABLE, {a,b} -> expected bit).

Verification
REQ-032 SHALL verify: start, then XNOR-correct samples 00/1, 01/0, 10/0, 11/1 -> cov_map 4'b1111, err_count 0, done=1 and pass=1 one cycle after the last accept.
REQ-033 SHALL verify: same sequence with 01/1 -> mismatch pulse one cycle after that accept, err_count 1, pass 0, and (macro on) first_err_vec 3'b011.
REQ-034 SHALL verify: ERR_W=2, 00/0 sent 5 times, then 01/0, 10/0, 11/1 -> err_count saturates at 3, done=1.
REQ-035 SHALL verify: start and in_valid high together in CHECK -> in_ready 0, cov_map cleared to 0, err_count 0.
REQ-036 SHALL verify: rst_n low after two accepts -> all outputs 0 and state IDLE; in_valid is then ignored until start.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] XOR_TT  = 4'b0110;
    localparam logic [3:0] XNOR_TT = 4'b1001;
    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] NOR_TT  = 4'b0001;

endpackage

// File: rtl/gate_chk_expect.sv
// Expected-response lookup: returns the truth-table bit selected by {a,b}.
module gate_chk_expect
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE = XNOR_TT
) (
    input  logic [1:0] ab,
    output logic       expected
);

    assign expected = TRUTH_TABLE[ab];

endmodule

// File: rtl/gate_resp_checker.sv
// Checks a 2-input gate's responses against a truth table; tracks coverage and errors per run.
// Optional first-error capture is enabled with macro GATE_RESP_CHECKER_FIRST_ERR_EN.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE = XNOR_TT,
    parameter int         ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       cov_map,
    output logic             mismatch,
    output logic             done,
    output logic             pass,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    chk_state_t state, state_next;

    logic       expected;
    logic       accept;
    logic       fail;
    logic [3:0] cov_next;

    gate_chk_expect #(
        .TRUTH_TABLE(TRUTH_TABLE)
    ) u_expect (
        .ab      ({a, b}),
        .expected(expected)
    );

    // start wins over a sample presented in the same cycle
    assign in_ready = (state == CHECK) && !start;
    assign accept   = in_valid && in_ready;
    assign fail     = accept && (y != expected);
    assign cov_next = accept ? (cov_map | (4'b0001 << {a, b})) : cov_map;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = CHECK;
            end
            CHECK: begin
                if (start)                 state_next = CHECK;
                else if (cov_next == 4'hF) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = CHECK;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
            cov_map   <= '0;
            mismatch  <= 1'b0;
        end else if (start) begin
            err_count <= '0;
            cov_map   <= '0;
            mismatch  <= 1'b0;
        end else begin
            cov_map  <= cov_next;
            mismatch <= fail;
            if (fail && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

`ifdef GATE_RESP_CHECKER_FIRST_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'b000;
        end else if (start) begin
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'b000;
        end else if (fail && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= {a, b, y};
        end
    end
`else
    assign first_err_valid = 1'b0;
    assign first_err_vec   = 3'b000;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: XNOR checker at ERR_W=8 and ERR_W=2 against a run-level model.
module tb_gate_resp_checker;

    logic clk = 1'b0;
    logic rst_n, start, in_valid, a, b, y;

    logic       rdy_a, mis_a, done_a, pass_a, fev_a;
    logic [7:0] err_a;
    logic [3:0] cov_a;
    logic [2:0] fe_a;

    logic       rdy_b, mis_b, done_b, pass_b, fev_b;
    logic [1:0] err_b;
    logic [3:0] cov_b;
    logic [2:0] fe_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_resp_checker #(.TRUTH_TABLE(4'b1001), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
        .a(a), .b(b), .y(y), .err_count(err_a), .cov_map(cov_a), .mismatch(mis_a),
        .done(done_a), .pass(pass_a), .first_err_valid(fev_a), .first_err_vec(fe_a)
    );

    gate_resp_checker #(.TRUTH_TABLE(4'b1001), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .a(a), .b(b), .y(y), .err_count(err_b), .cov_map(cov_b), .mismatch(mis_b),
        .done(done_b), .pass(pass_b), .first_err_valid(fev_b), .first_err_vec(fe_b)
    );

    // Run-level model: a run is active between start and full coverage.
    bit       m_running = 0, m_done = 0, m_mis = 0, m_fev = 0;
    bit [3:0] m_cov = 0;
    int       m_err8 = 0, m_err2 = 0;
    bit [2:0] m_fe = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_running = 0; m_done = 0; m_mis = 0; m_fev = 0;
            m_cov = 0; m_err8 = 0; m_err2 = 0; m_fe = 0;
        end else if (start) begin
            m_running = 1; m_done = 0; m_mis = 0; m_fev = 0;
            m_cov = 0; m_err8 = 0; m_err2 = 0; m_fe = 0;
        end else begin
            m_mis = 0;
            if (m_running && in_valid) begin
                m_cov[a * 2 + b] = 1'b1;
                if (y != !(a ^ b)) begin
                    m_mis = 1;
                    if (m_err8 < 255) m_err8++;
                    if (m_err2 < 3) m_err2++;
                    if (!m_fev) begin
                        m_fev = 1;
                        m_fe = {a, b, y};
                    end
                end
                if (m_cov == 4'hF) begin
                    m_running = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    bit exp_fev;
    bit [2:0] exp_fe;

    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
`ifdef GATE_RESP_CHECKER_FIRST_ERR_EN
            exp_fev = m_fev;
            exp_fe  = m_fe;
`else
            exp_fev = 1'b0;
            exp_fe  = 3'b000;
`endif
            chk("in_ready_a", int'(rdy_a), int'(m_running && !start));
            chk("err_count_a", int'(err_a), m_err8);
            chk("cov_map_a", int'(cov_a), int'(m_cov));
            chk("mismatch_a", int'(mis_a), int'(m_mis));
            chk("done_a", int'(done_a), int'(m_done));
            chk("pass_a", int'(pass_a), int'(m_done && m_err8 == 0));
            chk("first_err_valid_a", int'(fev_a), int'(exp_fev));
            chk("first_err_vec_a", int'(fe_a), int'(exp_fe));
            chk("err_count_b", int'(err_b), m_err2);
            chk("done_b", int'(done_b), int'(m_done));
            chk("pass_b", int'(pass_b), int'(m_done && m_err2 == 0));
        end
    end

    // Present inputs for one cycle; returns 2 time units after the sampling edge.
    task automatic step(input bit s, input bit v, input bit ia, input bit ib, input bit iy);
        start = s; in_valid = v; a = ia; b = ib; y = iy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; in_valid = 0; a = 0; b = 0; y = 0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("reset_cov", int'(cov_a), 0);
        chk("reset_ready", int'(rdy_a), 0);
        chk("reset_done", int'(done_a), 0);
        rst_n = 1;
        idle();

        // clean XNOR run
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1);
        chk("clean_cov", int'(cov_a), 15);
        chk("clean_err", int'(err_a), 0);
        chk("clean_done", int'(done_a), 1);
        chk("clean_pass", int'(pass_a), 1);
        step(0, 1, 0, 1, 1);  // ignored in DONE
        chk("done_ignores_err", int'(err_a), 0);
        chk("done_ignores_mis", int'(mis_a), 0);

        // one wrong response at 01
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        chk("err_mismatch_pulse", int'(mis_a), 1);
        step(0, 1, 1, 0, 0);
        chk("err_mismatch_drop", int'(mis_a), 0);
        step(0, 1, 1, 1, 1);
        chk("err_count_1", int'(err_a), 1);
        chk("err_done", int'(done_a), 1);
        chk("err_pass", int'(pass_a), 0);
`ifdef GATE_RESP_CHECKER_FIRST_ERR_EN
        chk("first_err_vec", int'(fe_a), 3);
        chk("first_err_valid", int'(fev_a), 1);
`else
        chk("first_err_vec_tied", int'(fe_a), 0);
`endif
        idle();

        // saturation on the ERR_W=2 instance
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        chk("sat_not_done", int'(done_b), 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1);
        chk("sat_err_b", int'(err_b), 3);
        chk("sat_err_a", int'(err_a), 5);
        chk("sat_done_b", int'(done_b), 1);
        idle();

        // start collides with a sample in CHECK
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("restart_pre_cov", int'(cov_a), 1);
        start = 1; in_valid = 1; a = 1; b = 1; y = 1;
        #1;
        chk("restart_ready", int'(rdy_a), 0);
        @(posedge clk); #2;
        chk("restart_cov", int'(cov_a), 0);
        chk("restart_err", int'(err_a), 0);
        idle();

        // reset mid-run
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        chk("mid_cov", int'(cov_a), 3);
        rst_n = 0;
        idle();
        chk("rst_cov", int'(cov_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_fev", int'(fev_a), 0);
        rst_n = 1;
        step(0, 1, 1, 0, 1);
        chk("idle_ignore_cov", int'(cov_a), 0);
        chk("idle_ignore_err", int'(err_a), 0);
        chk("idle_ready", int'(rdy_a), 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("after_rst_cov", int'(cov_a), 4);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
